// File: rtl/tt_pg_seq.sv
// ============================================================================
// tt_pg_seq : power-gating sequencer (switch ramp, isolation, reset ordering)
// Optional ramp abort selected by macro TT_PG_SEQ_ABORT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module tt_pg_seq #(
  parameter int N_SW      = 4,
  parameter int STAGE_DLY = 8,
  parameter int RST_DLY   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_on,
  output logic [N_SW-1:0] pg_ctrl,
  output logic            iso_n,
  output logic            prj_rst_n,
  output logic            pwr_good,
  output logic            busy
);

  localparam int MAX_DLY = (STAGE_DLY > RST_DLY) ? STAGE_DLY : RST_DLY;
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam logic [CNT_W-1:0] STG_LOAD = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_DLY - 1);
  localparam logic [N_SW-1:0]  PG_ONE   = N_SW'(1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_RAMP     = 3'd1,
    S_ISO_WAIT = 3'd2,
    S_ON       = 3'd3,
    S_RST_WAIT = 3'd4,
    S_CUT      = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [N_SW-1:0]   pg_nx;
  logic              iso_nx, rstn_nx, pwr_nx, busy_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OFF;
      cnt       <= '0;
      pg_ctrl   <= '0;
      iso_n     <= 1'b0;
      prj_rst_n <= 1'b0;
      pwr_good  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pg_ctrl   <= pg_nx;
      iso_n     <= iso_nx;
      prj_rst_n <= rstn_nx;
      pwr_good  <= pwr_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pg_nx    = pg_ctrl;
    iso_nx   = iso_n;
    rstn_nx  = prj_rst_n;

    case (state)
      S_OFF: begin
        pg_nx   = '0;
        iso_nx  = 1'b0;
        rstn_nx = 1'b0;
        cnt_nx  = '0;
        if (req_on) begin
          state_nx = S_RAMP;
          pg_nx    = PG_ONE;
          cnt_nx   = STG_LOAD;
        end
      end

      S_RAMP: begin
`ifdef TT_PG_SEQ_ABORT_EN
        if (!req_on) begin
          state_nx = S_CUT;
          iso_nx   = 1'b0;
        end else
`endif
        if (cnt == '0) begin
          // Segments close strictly in order; isolation lifts only once all are closed.
          if (&pg_ctrl) begin
            state_nx = S_ISO_WAIT;
            iso_nx   = 1'b1;
            cnt_nx   = RST_LOAD;
          end else begin
            pg_nx  = (pg_ctrl << 1) | PG_ONE;
            cnt_nx = STG_LOAD;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      S_ISO_WAIT: begin
`ifdef TT_PG_SEQ_ABORT_EN
        if (!req_on) begin
          state_nx = S_CUT;
          iso_nx   = 1'b0;
        end else
`endif
        if (cnt == '0) begin
          state_nx = S_ON;
          rstn_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      S_ON: begin
        if (!req_on) begin
          state_nx = S_RST_WAIT;
          rstn_nx  = 1'b0;
          cnt_nx   = RST_LOAD;
        end
      end

      S_RST_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_CUT;
          iso_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      S_CUT: begin
        state_nx = S_OFF;
        pg_nx    = '0;
        iso_nx   = 1'b0;
        rstn_nx  = 1'b0;
        cnt_nx   = '0;
      end

      default: begin
        state_nx = S_OFF;
        pg_nx    = '0;
        iso_nx   = 1'b0;
        rstn_nx  = 1'b0;
        cnt_nx   = '0;
      end
    endcase

    pwr_nx  = (state_nx == S_ON);
    busy_nx = (state_nx != S_ON) && (state_nx != S_OFF);
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_pg_seq.sv
// ============================================================================
// tb_tt_pg_seq : table vectors, directed corner sequences and a random run
// against a timeline-based reference model of tt_pg_seq.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_tt_pg_seq;

  localparam int N = 4;
  localparam int S = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_on = 1'b0;
  logic [N-1:0] pg_ctrl;
  logic         iso_n, prj_rst_n, pwr_good, busy;

  int vectors     = 0;
  int miscompares = 0;

  tt_pg_seq #(.N_SW(N), .STAGE_DLY(S), .RST_DLY(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_on    (req_on),
    .pg_ctrl   (pg_ctrl),
    .iso_n     (iso_n),
    .prj_rst_n (prj_rst_n),
    .pwr_good  (pwr_good),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed edges since power-up / power-down began.
  int           m_mode = 0;   // 0 off, 1 powering up or on, 2 powering down, 3 abort cut
  int           m_age  = 0;
  logic [N-1:0] m_frozen = '0;

  function automatic logic [N-1:0] thermo(input int age);
    int k;
    k = age / S + 1;
    if (k > N) k = N;
    return N'((1 << k) - 1);
  endfunction

  function automatic logic [N+3:0] model_out();
    logic on;
    case (m_mode)
      1: begin
        on = (m_age >= N*S + R);
        return {thermo(m_age), (m_age >= N*S), on, on, ~on};
      end
      2: return {{N{1'b1}}, (m_age < R), 1'b0, 1'b0, 1'b1};
      3: return {m_frozen, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return '0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic q);
    logic on;
    if (r) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (q) begin m_mode = 1; m_age = 0; end
        1: begin
          on = (m_age >= N*S + R);
          if (on && !q) begin m_mode = 2; m_age = 0; end
`ifdef TT_PG_SEQ_ABORT_EN
          else if (!on && !q) begin m_frozen = thermo(m_age); m_mode = 3; end
`endif
          else if (!on) m_age++;
        end
        2: if (m_age == R) m_mode = 0; else m_age++;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic q, input int n);
    rst    = r;
    req_on = q;
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge(r, q);
    end
  endtask

  task automatic check(input string name, input logic [N+3:0] exp);
    logic [N+3:0] act;
    act = {pg_ctrl, iso_n, prj_rst_n, pwr_good, busy};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got pg/iso/rstn/pwr/busy=%b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         r;
    logic         q;
    int           n;
    logic [N+3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic q, input int n,
                     input logic [N+3:0] e);
    vec_t v;
    v.name = nm; v.r = r; v.q = q; v.n = n; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic         q;
    int           cyc;
    int           hold;
    int           last_set;
    logic [N-1:0] prev_pg;

    // {pg_ctrl, iso_n, prj_rst_n, pwr_good, busy} after the last of n edges
    add("reset",          1, 0, 2, 8'b0000_0000);
    add("ramp_T",         0, 1, 1, 8'b0001_0001);
    add("ramp_T7",        0, 1, 7, 8'b0001_0001);
    add("ramp_T8",        0, 1, 1, 8'b0011_0001);
    add("ramp_T16",       0, 1, 8, 8'b0111_0001);
    add("ramp_T24",       0, 1, 8, 8'b1111_0001);
    add("iso_T31",        0, 1, 7, 8'b1111_0001);
    add("iso_T32",        0, 1, 1, 8'b1111_1001);
    add("iso_T35",        0, 1, 3, 8'b1111_1001);
    add("on_T36",         0, 1, 1, 8'b1111_1110);
    add("on_hold",        0, 1, 5, 8'b1111_1110);
    add("down_D",         0, 0, 1, 8'b1111_1001);
    add("down_D3_req1",   0, 1, 3, 8'b1111_1001);
    add("cut_D4_req1",    0, 1, 1, 8'b1111_0001);
    add("off_D5_req1",    0, 1, 1, 8'b0000_0000);
    add("reramp_D6",      0, 1, 1, 8'b0001_0001);
    add("rst_prio",       1, 1, 2, 8'b0000_0000);
    add("rst_release",    0, 1, 1, 8'b0001_0001);
    add("ramp_after_rel", 0, 1, 8, 8'b0011_0001);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].n);
      check(tbl[i].name, tbl[i].exp);
    end

    // Reset mid-ramp, then restart with req_on held
    step(1, 0, 2);
    step(0, 1, 1);
    check("mr_T", 8'b0001_0001);
    step(0, 1, 19);
    check("mr_T19", 8'b0111_0001);
    step(1, 1, 1);
    check("mr_rst_T20", 8'b0000_0000);
    step(0, 1, 1);
    check("mr_restart", 8'b0001_0001);
    step(0, 1, 8);
    check("mr_restart8", 8'b0011_0001);

    // Short request pulse: high at T..T+9, low from T+10
    step(1, 0, 2);
    step(0, 1, 1);
    step(0, 1, 9);
    check("pulse_T9", 8'b0011_0001);
    step(0, 0, 1);
`ifdef TT_PG_SEQ_ABORT_EN
    check("abort_T10", 8'b0011_0001);
    step(0, 0, 1);
    check("abort_T11", 8'b0000_0000);
    step(0, 0, 5);
    check("abort_stay_off", 8'b0000_0000);
`else
    check("noabort_T10", 8'b0011_0001);
    step(0, 0, 26);
    check("noabort_on_T36", 8'b1111_1110);
    step(0, 0, 1);
    check("noabort_down_T37", 8'b1111_1001);
    step(0, 0, 4);
    check("noabort_cut_T41", 8'b1111_0001);
    step(0, 0, 1);
    check("noabort_off_T42", 8'b0000_0000);
`endif

    // Randomized request toggling against the reference model
    step(1, 0, 2);
    q        = 1'b0;
    cyc      = 0;
    last_set = -1000;
    prev_pg  = '0;
    while (cyc < 2000) begin
      hold = $urandom_range(1, 60);
      q    = ~q;
      repeat (hold) begin
        step(0, q, 1);
        cyc++;
        check("rand_model", model_out());
        vectors++;
        if ((iso_n && !(&pg_ctrl)) || (prj_rst_n && !iso_n)) begin
          miscompares++;
          $display("FAIL ordering @%0d: got pg=%b iso_n=%b prj_rst_n=%b expected ordered",
                   cyc, pg_ctrl, iso_n, prj_rst_n);
        end
        if ((pg_ctrl & ~prev_pg) != '0) begin
`ifndef TT_PG_SEQ_ABORT_EN
          vectors++;
          if (cyc - last_set < S) begin
            miscompares++;
            $display("FAIL set_gap @%0d: got %0d cycles expected >= %0d",
                     cyc, cyc - last_set, S);
          end
`endif
          last_set = cyc;
        end
        prev_pg = pg_ctrl;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
